// File: rtl/cipher_pkg.sv
// cipher_pkg: shared ASCII constants, controller state encoding and letter test
package cipher_pkg;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [5:0] ALPHABET = 6'd26;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction
endpackage

// File: rtl/cipher_shift_unit.sv
// cipher_shift_unit: combinational Caesar/Vigenere letter shift; non-letters pass through
module cipher_shift_unit
    import cipher_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] i_char,
    input  logic [4:0]        i_shift,
    input  logic              i_decrypt,
    output logic [CHAR_W-1:0] o_char
);
    logic       w_letter;
    logic [5:0] w_pos;
    logic [5:0] w_sum;
    logic [5:0] w_wrap;
    assign w_letter = (i_char >= CHAR_W'(ASCII_A)) && (i_char <= CHAR_W'(ASCII_Z));
    assign w_pos    = 6'(i_char - CHAR_W'(ASCII_A));
    // Decrypt adds the complement so the sum never goes negative; one conditional subtract wraps both paths
    assign w_sum    = i_decrypt ? w_pos + ALPHABET - {1'b0, i_shift} : w_pos + {1'b0, i_shift};
    assign w_wrap   = (w_sum >= ALPHABET) ? w_sum - ALPHABET : w_sum;
    assign o_char   = w_letter ? CHAR_W'(ASCII_A) + CHAR_W'(w_wrap) : i_char;
endmodule

// File: rtl/cipher_stream_controller.sv
// cipher_stream_controller: sequences a valid/ready character stream through one shared shift unit
module cipher_stream_controller
    import cipher_pkg::*;
#(
    parameter int KEY_CHARS = 10,
    parameter int CHAR_W    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   stop,
    input  logic                   mode,
    input  logic                   decrypt,
    input  logic [4:0]             shiftCount,
    input  logic [8*KEY_CHARS-1:0] keyInput,
    input  logic [3:0]             keyLength,
    input  logic                   inValid,
    input  logic [CHAR_W-1:0]      inChar,
    output logic                   inReady,
    output logic                   outValid,
    output logic [CHAR_W-1:0]      outChar,
    input  logic                   outReady,
    output logic                   busy,
    output logic                   keyError
);
    logic [1:0]             r_state;
    logic                   r_mode;
    logic                   r_decrypt;
    logic [4:0]             r_shift;
    logic [8*KEY_CHARS-1:0] r_key;
    logic [3:0]             r_key_len;
    logic [3:0]             r_key_ptr;
    logic                   r_out_valid;
    logic [CHAR_W-1:0]      r_out_char;
    logic                   r_key_error;
    logic                   w_key_bad;
    logic                   w_cfg_ok;
    logic [7:0]             w_key_byte;
    logic [4:0]             w_shift;
    logic                   w_xfer;
    logic                   w_in_letter;
    logic [3:0]             w_ptr_next;
    logic [CHAR_W-1:0]      w_out_char;
    always_comb begin
        w_key_bad  = 1'b0;
        w_key_byte = 8'h00;
        for (int i = 0; i < KEY_CHARS; i++) begin
            if (i < int'(keyLength) && !is_upper(keyInput[8*i +: 8])) w_key_bad = 1'b1;
            if (4'(i) == r_key_ptr) w_key_byte = r_key[8*i +: 8];
        end
        w_cfg_ok = (keyLength != 4'd0) && (int'(keyLength) <= KEY_CHARS) &&
                   (mode ? !w_key_bad : shiftCount <= 5'd25);
    end
    assign w_shift     = r_mode ? 5'(w_key_byte - ASCII_A) : r_shift;
    assign inReady     = (r_state == RUN) && (!r_out_valid || outReady);
    assign w_xfer      = inValid && inReady;
    assign w_in_letter = (inChar >= CHAR_W'(ASCII_A)) && (inChar <= CHAR_W'(ASCII_Z));
    assign w_ptr_next  = (r_key_ptr == r_key_len - 4'd1) ? 4'd0 : r_key_ptr + 4'd1;
    cipher_shift_unit #(.CHAR_W(CHAR_W)) u_shift (
        .i_char    (inChar),
        .i_shift   (w_shift),
        .i_decrypt (r_decrypt),
        .o_char    (w_out_char)
    );
    // Transfers always use the registered config, so a load in the same cycle affects only later characters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_decrypt   <= 1'b0;
            r_shift     <= 5'd0;
            r_key       <= '0;
            r_key_len   <= 4'd0;
            r_key_ptr   <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
            r_key_error <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_char  <= w_out_char;
            end else if (outReady) begin
                r_out_valid <= 1'b0;
            end
            if (w_xfer && r_mode && w_in_letter) r_key_ptr <= w_ptr_next;
            if (load && r_state != DRAIN) begin
                r_key_error <= !w_cfg_ok;
                if (w_cfg_ok) begin
                    r_mode    <= mode;
                    r_decrypt <= decrypt;
                    r_shift   <= shiftCount;
                    r_key     <= keyInput;
                    r_key_len <= keyLength;
                    r_key_ptr <= 4'd0;
                    r_state   <= RUN;
                end
            end else if (r_state == RUN && stop) begin
                r_state <= DRAIN;
            end else if (r_state == DRAIN && (!r_out_valid || outReady)) begin
                r_state <= IDLE;
            end
        end
    end
    assign outValid = r_out_valid;
    assign outChar  = r_out_char;
    assign busy     = r_state != IDLE;
    assign keyError = r_key_error;
endmodule
